// File: rtl/hex_fmt_pkg.sv
// Shared types and ASCII constants for the hex line formatter.
package hex_fmt_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    COLON,
    SPACE,
    DATA,
    CR,
    LF
  } state_e;

  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_A     = 8'h41;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit nibble to uppercase ASCII hex digit.
module hex_nibble_to_ascii
  import hex_fmt_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  always_comb begin
    if (nibble_i < 4'd10) ascii_o = CH_0 + {4'h0, nibble_i};
    else                  ascii_o = CH_A + {4'h0, nibble_i} - 8'd10;
  end

endmodule

// File: rtl/hex_line_formatter.sv
// Serialises {address, data} records into "AAAAAA: DDDDDDDD\r\n" lines,
// one byte per emitter ready pulse; all outputs registered.
module hex_line_formatter
  import hex_fmt_pkg::*;
#(
  parameter int ADDR_W = 24,
  parameter int DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_ready,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic [15:0]       o_line_cnt
);

  localparam int ADDR_NIB = ADDR_W / 4;
  localparam int DATA_NIB = DATA_W / 4;
  localparam int MAX_NIB  = (ADDR_NIB > DATA_NIB) ? ADDR_NIB : DATA_NIB;
  localparam int IDX_W    = (MAX_NIB > 1) ? $clog2(MAX_NIB) : 1;

  localparam logic [IDX_W-1:0] ADDR_TOP = IDX_W'(ADDR_NIB - 1);
  localparam logic [IDX_W-1:0] DATA_TOP = IDX_W'(DATA_NIB - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_valid_q, tx_valid_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic [15:0]       line_cnt_q, line_cnt_d;

  logic              advance;
  logic [3:0]        nibble;
  logic [7:0]        hex_char;

  assign advance = tx_valid_q & i_tx_ready;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    addr_d     = addr_q;
    data_d     = data_q;
    tx_valid_d = tx_valid_q;
    ready_d    = ready_q;
    line_cnt_d = line_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (i_valid && ready_q) begin
          addr_d     = i_addr;
          data_d     = i_data;
          idx_d      = ADDR_TOP;
          state_d    = ADDR;
          tx_valid_d = 1'b1;
          ready_d    = 1'b0;
        end
      end
      ADDR: begin
        if (advance) begin
          if (idx_q == '0) state_d = COLON;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      COLON: if (advance) state_d = SPACE;
      SPACE: begin
        if (advance) begin
          state_d = DATA;
          idx_d   = DATA_TOP;
        end
      end
      DATA: begin
        if (advance) begin
          if (idx_q == '0) state_d = CR;
          else             idx_d   = idx_q - 1'b1;
        end
      end
      CR: if (advance) state_d = LF;
      LF: begin
        if (advance) begin
          state_d    = IDLE;
          tx_valid_d = 1'b0;
          ready_d    = 1'b1;
          line_cnt_d = line_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = ~ready_d;
  end

  // The byte register is loaded from the next-state view so each byte is
  // presented the cycle after acceptance or after the previous pulse.
  always_comb begin
    if (state_d == DATA) nibble = 4'(data_d >> (4 * idx_d));
    else                 nibble = 4'(addr_d >> (4 * idx_d));
  end

  hex_nibble_to_ascii u_hex (
    .nibble_i (nibble),
    .ascii_o  (hex_char)
  );

  always_comb begin
    unique case (state_d)
      ADDR, DATA: tx_data_d = hex_char;
      COLON:      tx_data_d = CH_COLON;
      SPACE:      tx_data_d = CH_SPACE;
      CR:         tx_data_d = CH_CR;
      LF:         tx_data_d = CH_LF;
      default:    tx_data_d = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      line_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      line_cnt_q <= line_cnt_d;
    end
  end

  assign o_ready    = ready_q;
  assign o_busy     = busy_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_valid = tx_valid_q;
  assign o_line_cnt = line_cnt_q;

endmodule

// File: tb/tb_hex_line_formatter.sv
// Randomised self-checking bench for hex_line_formatter, default and 4/8-bit instances.
module tb_hex_line_formatter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        valid = 1'b0;
  logic        tx_ready = 1'b0;
  logic        sel = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] data = '0;

  logic        b_valid, b_tx_ready, b_ready, b_tx_valid, b_busy;
  logic [7:0]  b_tx_data;
  logic [15:0] b_cnt;
  logic        s_valid, s_tx_ready, s_ready, s_tx_valid, s_busy;
  logic [7:0]  s_tx_data;
  logic [15:0] s_cnt;

  logic        obs_ready, obs_tx_valid, obs_busy;
  logic [7:0]  obs_tx_data;
  logic [15:0] obs_cnt;

  assign b_valid    = valid & ~sel;
  assign b_tx_ready = tx_ready & ~sel;
  assign s_valid    = valid & sel;
  assign s_tx_ready = tx_ready & sel;

  assign obs_ready    = sel ? s_ready    : b_ready;
  assign obs_tx_valid = sel ? s_tx_valid : b_tx_valid;
  assign obs_busy     = sel ? s_busy     : b_busy;
  assign obs_tx_data  = sel ? s_tx_data  : b_tx_data;
  assign obs_cnt      = sel ? s_cnt      : b_cnt;

  hex_line_formatter u_big (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (b_valid),
    .i_addr     (addr),
    .i_data     (data),
    .o_ready    (b_ready),
    .o_tx_data  (b_tx_data),
    .o_tx_valid (b_tx_valid),
    .i_tx_ready (b_tx_ready),
    .o_busy     (b_busy),
    .o_line_cnt (b_cnt)
  );

  hex_line_formatter #(.ADDR_W(4), .DATA_W(8)) u_small (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_valid    (s_valid),
    .i_addr     (addr[3:0]),
    .i_data     (data[7:0]),
    .o_ready    (s_ready),
    .o_tx_data  (s_tx_data),
    .o_tx_valid (s_tx_valid),
    .i_tx_ready (s_tx_ready),
    .o_busy     (s_busy),
    .o_line_cnt (s_cnt)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_lines [2] = '{0, 0};
  logic [31:0] rec_a [8];
  logic [31:0] rec_d [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ch(input int v);
    return (v < 10) ? 8'(48 + v) : 8'(55 + v);
  endfunction

  // Emitter + upstream model: offers rec_a/rec_d[0..n-1], pulses tx_ready
  // 'gap' cycles after each byte appears, compares against the expected text.
  task automatic stream(input int n, input int gap, input bit hold, input bit noise,
                        input int abort_after);
    logic [7:0] exp_q [$];
    logic [7:0] first_seen = 8'h00;
    logic [7:0] e;
    int r = 0, wait_c = 0, pulses = 0, budget = 0, lf_cyc = 0;
    int aw = sel ? 4 : 24;
    int dw = sel ? 8 : 32;
    bit byte_open = 0, after_lf = 0, lf_seen = 0, prev_valid = 0;
    do begin
      @(negedge clk);
      tx_ready = 1'b0;
      if (after_lf) begin
        check("post_lf_ready", obs_ready, 1);
        check("post_lf_busy", obs_busy, 0);
        check("post_lf_txv", obs_tx_valid, 0);
        after_lf = 0;
      end
      if (hold && lf_seen && obs_tx_valid && !prev_valid) begin
        check("b2b_gap", cyc - lf_cyc, 2);
        lf_seen = 0;
      end
      if (obs_tx_valid) begin
        if (!byte_open) begin
          first_seen = obs_tx_data;
          byte_open  = 1;
          wait_c     = 0;
        end
        if (wait_c >= gap) begin
          tx_ready  = 1'b1;
          byte_open = 0;
          pulses++;
          if (gap > 0) check("stable", obs_tx_data, first_seen);
          if (exp_q.size() == 0) check("unexpected_byte", obs_tx_valid, 0);
          else begin
            e = exp_q.pop_front();
            check("byte", obs_tx_data, e);
            if (e == 8'h0A) begin
              after_lf = 1;
              lf_seen  = 1;
              lf_cyc   = cyc;
              exp_lines[sel]++;
            end
          end
        end else wait_c++;
      end else if (noise) begin
        tx_ready = ($urandom_range(0, 3) == 0);
      end
      if (abort_after > 0 && pulses == abort_after) return;
      if (r < n) begin
        valid = (hold || !noise) ? 1'b1 : 1'($urandom_range(0, 1));
        addr  = rec_a[r][23:0];
        data  = rec_d[r];
        if (valid && obs_ready) begin
          for (int i = aw / 4 - 1; i >= 0; i--)
            exp_q.push_back(hex_ch(int'((rec_a[r] >> (4 * i)) & 32'hF)));
          exp_q.push_back(8'h3A);
          exp_q.push_back(8'h20);
          for (int i = dw / 4 - 1; i >= 0; i--)
            exp_q.push_back(hex_ch(int'((rec_d[r] >> (4 * i)) & 32'hF)));
          exp_q.push_back(8'h0D);
          exp_q.push_back(8'h0A);
          r++;
        end
      end else begin
        valid = 1'b0;
      end
      prev_valid = obs_tx_valid;
      budget++;
      if (budget > 20000) begin
        check("timeout_cycles", budget, 0);
        break;
      end
    end while (r < n || exp_q.size() > 0 || after_lf);
    valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, obs_ready, 1);
    check({tag, "_txv"}, obs_tx_valid, 0);
    check({tag, "_txd"}, obs_tx_data, 0);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_cnt"}, obs_cnt, 0);
  endtask

  initial begin
    // Reset values on both instances.
    @(negedge clk);
    #1;
    sel = 1'b0; #0 check_reset_outputs("rst_big");
    sel = 1'b1; #0 check_reset_outputs("rst_small");
    sel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Single record with a slow emitter.
    rec_a[0] = 32'h001A2B; rec_d[0] = 32'hDEADBEEF;
    stream(1, 200, 1'b0, 1'b0, 0);
    check("cnt_single", obs_cnt, exp_lines[0]);

    // Nibble boundary digits and leading zeros.
    rec_a[0] = 32'hFFFFFF; rec_d[0] = 32'h09AF0000;
    stream(1, 3, 1'b0, 1'b0, 0);

    // Back-to-back random records, ready every cycle.
    for (int i = 0; i < 3; i++) begin
      rec_a[i] = $urandom & 32'hFFFFFF;
      rec_d[i] = $urandom;
    end
    stream(3, 0, 1'b1, 1'b0, 0);
    check("cnt_b2b", obs_cnt, exp_lines[0]);

    // Spurious ready pulses while idle produce nothing.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      tx_ready = 1'($urandom_range(0, 1));
      check("idle_no_byte", obs_tx_valid, 0);
    end
    @(negedge clk);
    tx_ready = 1'b0;
    check("idle_cnt", obs_cnt, exp_lines[0]);

    // Random valid toggling with the next record on the bus mid-line.
    for (int i = 0; i < 4; i++) begin
      rec_a[i] = $urandom & 32'hFFFFFF;
      rec_d[i] = $urandom;
    end
    stream(4, 2, 1'b0, 1'b1, 0);
    check("cnt_noise", obs_cnt, exp_lines[0]);

    // Asynchronous reset after the 5th byte of a line.
    rec_a[0] = $urandom & 32'hFFFFFF; rec_d[0] = $urandom;
    stream(1, 1, 1'b0, 1'b0, 5);
    @(negedge clk);
    tx_ready = 1'b0;
    valid    = 1'b0;
    rst      = 1'b1;
    #1;
    check_reset_outputs("midline_rst");
    exp_lines = '{0, 0};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tx_ready = 1'b1;
      check("post_rst_quiet", obs_tx_valid, 0);
    end
    tx_ready = 1'b0;
    rec_a[0] = $urandom & 32'hFFFFFF; rec_d[0] = $urandom;
    stream(1, 0, 1'b0, 1'b0, 0);
    check("cnt_after_rst", obs_cnt, exp_lines[0]);

    // Narrow instance: "7: C3\r\n" then random back-to-back lines.
    sel = 1'b1;
    rec_a[0] = 32'h7; rec_d[0] = 32'hC3;
    stream(1, 1, 1'b0, 1'b0, 0);
    check("cnt_small", obs_cnt, exp_lines[1]);
    for (int i = 0; i < 3; i++) begin
      rec_a[i] = $urandom_range(0, 15);
      rec_d[i] = $urandom_range(0, 255);
    end
    stream(3, 0, 1'b1, 1'b0, 0);
    check("cnt_small_b2b", obs_cnt, exp_lines[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
